// File: rtl/capture_arbiter.sv
// Two-port snoop capture: per-port FIFOs, round-robin into one Avalon-MM write master.
// Optional drop counters via CAPTURE_ARBITER_DROP_CNT_EN (default build: counters absent).
module capture_arbiter #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [35:0]       port0_st_data,
    input  logic              port0_st_valid,
    input  logic [35:0]       port1_st_data,
    input  logic              port1_st_valid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [63:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [3:0]        csr_address,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              snoop_reset
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [35:0]       r_fifo0 [DEPTH];
    logic [35:0]       r_fifo1 [DEPTH];
    logic [AW:0]       r_rd0, r_wr0, r_rd1, r_wr1;
    logic              r_mem_write, r_grant, r_last;
    logic [ADDR_W-1:0] r_mem_address, r_wrptr, r_limit;
    logic [63:0]       r_mem_writedata;
    logic              r_wrap, r_snoop_rst;
    logic [31:0]       r_csr_readdata;

    logic [AW:0]       w_cnt0, w_cnt1;
    logic [AW-1:0]     w_hidx0, w_hidx1;
    logic [35:0]       w_head0, w_head1;
    logic              w_acc, w_pop0, w_pop1, w_ne0, w_ne1, w_full0, w_full1;
    logic              w_push0, w_push1, w_arm, w_stop, w_ctrl_wr;
    logic              w_at_limit, w_oneshot_end, w_active, w_load, w_sel, w_clear, w_flush;
    logic [ADDR_W-1:0] w_wrptr_nxt;
    logic [19:0]       w_ptr20;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_unused = ^csr_writedata[31:4];

    assign w_cnt0  = r_wr0 - r_rd0;
    assign w_cnt1  = r_wr1 - r_rd1;
    assign w_acc   = r_mem_write & ~mem_waitrequest;
    assign w_pop0  = w_acc & ~r_grant;
    assign w_pop1  = w_acc & r_grant;
    // Arbitrate on the post-pop view so a new word can launch in the same cycle one is accepted.
    assign w_ne0   = w_cnt0 > (AW+1)'(w_pop0);
    assign w_ne1   = w_cnt1 > (AW+1)'(w_pop1);
    assign w_hidx0 = r_rd0[AW-1:0] + AW'(w_pop0);
    assign w_hidx1 = r_rd1[AW-1:0] + AW'(w_pop1);
    assign w_head0 = r_fifo0[w_hidx0];
    assign w_head1 = r_fifo1[w_hidx1];
    assign w_full0 = w_cnt0 == (AW+1)'(DEPTH);
    assign w_full1 = w_cnt1 == (AW+1)'(DEPTH);

    assign w_ctrl_wr     = csr_write & (csr_address == 4'd0);
    assign w_arm         = w_ctrl_wr & csr_writedata[0];
    assign w_stop        = w_ctrl_wr & csr_writedata[1];
    assign w_at_limit    = r_wrptr == r_limit;
    assign w_oneshot_end = w_acc & w_at_limit & ~r_wrap;
    assign w_wrptr_nxt   = w_acc ? ((w_at_limit && r_wrap) ? '0 : r_wrptr + 1'b1) : r_wrptr;
    assign w_ptr20       = 20'(w_wrptr_nxt);
    assign w_active      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_load        = w_active & (~r_mem_write | w_acc) & ~w_oneshot_end & (w_ne0 | w_ne1);
    assign w_sel         = (w_ne0 & w_ne1) ? ~r_last : w_ne1;
    assign w_clear       = w_arm & ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_flush       = w_clear | w_oneshot_end;
    assign w_push0       = (r_state == ST_RUN) & port0_st_valid & (~w_full0 | w_pop0);
    assign w_push1       = (r_state == ST_RUN) & port1_st_valid & (~w_full1 | w_pop1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_arm) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_oneshot_end)  w_state_nxt = ST_DONE;
                else if (w_stop)    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_oneshot_end)  w_state_nxt = ST_DONE;
                else if (!r_mem_write && w_cnt0 == '0 && w_cnt1 == '0) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_push0) r_fifo0[r_wr0[AW-1:0]] <= port0_st_data;
        if (w_push1) r_fifo1[r_wr1[AW-1:0]] <= port1_st_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || w_flush) begin
            r_rd0 <= '0;
            r_wr0 <= '0;
            r_rd1 <= '0;
            r_wr1 <= '0;
        end else begin
            if (w_push0) r_wr0 <= r_wr0 + 1'b1;
            if (w_pop0)  r_rd0 <= r_rd0 + 1'b1;
            if (w_push1) r_wr1 <= r_wr1 + 1'b1;
            if (w_pop1)  r_rd1 <= r_rd1 + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_grant         <= 1'b0;
            r_last          <= 1'b1;
            r_wrptr         <= '0;
        end else begin
            if (w_clear)    r_wrptr <= '0;
            else if (w_acc) r_wrptr <= w_wrptr_nxt;
            if (w_load) begin
                r_mem_write     <= 1'b1;
                r_mem_address   <= w_wrptr_nxt;
                r_mem_writedata <= {4'hF, w_sel, 3'b000, w_ptr20, (w_sel ? w_head1 : w_head0)};
                r_grant         <= w_sel;
                r_last          <= w_sel;
            end else if (w_acc) begin
                r_mem_write <= 1'b0;
            end
        end
    end

`ifdef CAPTURE_ARBITER_DROP_CNT_EN
    logic [31:0] r_drop0, r_drop1;
    logic        w_drop0, w_drop1;
    assign w_drop0 = (r_state == ST_RUN) & port0_st_valid & w_full0 & ~w_pop0 & ~w_flush;
    assign w_drop1 = (r_state == ST_RUN) & port1_st_valid & w_full1 & ~w_pop1 & ~w_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || w_clear) begin
            r_drop0 <= '0;
            r_drop1 <= '0;
        end else begin
            if (w_drop0 && r_drop0 != '1) r_drop0 <= r_drop0 + 1'b1;
            if (w_drop1 && r_drop1 != '1) r_drop1 <= r_drop1 + 1'b1;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (csr_address)
            4'd0: w_rdata = {28'b0, r_snoop_rst, r_wrap, 2'b00};
            4'd1: w_rdata = {30'b0, r_state};
            4'd2: w_rdata = 32'(r_limit);
            4'd3: w_rdata = 32'(r_wrptr);
`ifdef CAPTURE_ARBITER_DROP_CNT_EN
            4'd4: w_rdata = r_drop0;
            4'd5: w_rdata = r_drop1;
`endif
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_limit        <= '1;
            r_wrap         <= 1'b0;
            r_snoop_rst    <= 1'b0;
            r_csr_readdata <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_wrap      <= csr_writedata[2];
                r_snoop_rst <= csr_writedata[3];
            end
            if (csr_write && csr_address == 4'd2) r_limit <= csr_writedata[ADDR_W-1:0];
            if (csr_read) r_csr_readdata <= w_rdata;
        end
    end

    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;
    assign csr_readdata  = r_csr_readdata;
    assign snoop_reset   = r_snoop_rst;
endmodule

// File: tb/tb_capture_arbiter.sv
// Directed bench for capture_arbiter: expected memory words queued at stimulus, checked at accept.
module tb_capture_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [35:0] port0_st_data = '0, port1_st_data = '0;
    logic        port0_st_valid = 1'b0, port1_st_valid = 1'b0;
    logic [19:0] mem_address;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic        mem_waitrequest = 1'b0;
    logic [3:0]  csr_address = '0;
    logic        csr_write = 1'b0, csr_read = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic        snoop_reset;

    capture_arbiter #(.ADDR_W(20), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .port0_st_data(port0_st_data), .port0_st_valid(port0_st_valid),
        .port1_st_data(port1_st_data), .port1_st_valid(port1_st_valid),
        .mem_address(mem_address), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
        .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .snoop_reset(snoop_reset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] addr;
        logic [63:0] word;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_asserts = 0;
    int   n_fail = 0;

`ifdef CAPTURE_ARBITER_DROP_CNT_EN
    localparam int B_DROPS = 2;
`else
    localparam int B_DROPS = 0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] mk(input logic port, input logic [19:0] addr, input logic [35:0] beat);
        return {4'hF, port, 3'b000, addr, beat};
    endfunction

    function automatic logic [35:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    task automatic push(input logic port, input logic [19:0] addr, input logic [35:0] beat);
        q.push_back('{addr: addr, word: mk(port, addr, beat)});
    endtask

    task automatic apply_reset();
        port0_st_valid = 0; port1_st_valid = 0;
        csr_write = 0; csr_read = 0; mem_waitrequest = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        q.delete();
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        csr_address = a; csr_writedata = d; csr_write = 1;
        @(posedge clk); #1;
        csr_write = 0;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        csr_address = a; csr_read = 1;
        @(posedge clk); #1;
        csr_read = 0;
        d = csr_readdata;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk(tag, 64'(q.size()), 64'd0);
    endtask

    task automatic wait_mem_write(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_write) break;
        end
        chk(tag, 64'(mem_write), 64'd1);
    endtask

    // Every accepted write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && mem_write && !mem_waitrequest) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 64'(mem_address), 64'(e.addr));
                chk("wr_data", mem_writedata, e.word);
            end
        end
    end

    logic [31:0] rd;
    logic [19:0] hold_addr;
    logic [63:0] hold_data;
    logic [35:0] d0, d1;
    logic [19:0] a;

    initial begin
        // Reset values
        @(posedge clk); #1;
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_address", 64'(mem_address), 64'd0);
        chk("rst_mem_writedata", mem_writedata, 64'd0);
        chk("rst_csr_readdata", 64'(csr_readdata), 64'd0);
        chk("rst_snoop_reset", 64'(snoop_reset), 64'd0);
        apply_reset();
        csr_rd(4'd2, rd);
        chk("limit_reset", 64'(rd), 64'h000F_FFFF);
        csr_rd(4'd1, rd);
        chk("status_idle", 64'(rd), 64'd0);

        // A: one-shot fill, LIMIT=3, six port-0 beats
        csr_wr(4'd2, 32'd3);
        csr_wr(4'd0, 32'h1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            d0 = rnd36();
            port0_st_valid = 1; port0_st_data = d0;
            if (k < 4) push(1'b0, 20'(k), d0);
        end
        @(posedge clk); #1 port0_st_valid = 0;
        wait_empty("A_drain");
        repeat (4) @(posedge clk);
        csr_rd(4'd1, rd);
        chk("A_status_done", 64'(rd), 64'd3);
        csr_rd(4'd4, rd);
        chk("A_drop0", 64'(rd), 64'd0);

        // B: both ports every cycle, alternating grants, drops after fill
        apply_reset();
        csr_wr(4'd0, 32'h1);
        a = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            d0 = rnd36(); d1 = rnd36();
            port0_st_valid = 1; port0_st_data = d0;
            port1_st_valid = 1; port1_st_data = d1;
            if (k != 8 && k != 10) begin push(1'b0, a, d0); a++; end
            if (k != 7 && k != 9)  begin push(1'b1, a, d1); a++; end
        end
        @(posedge clk); #1;
        port0_st_valid = 0; port1_st_valid = 0;
        wait_empty("B_drain");
        csr_rd(4'd3, rd);
        chk("B_wrptr", 64'(rd), 64'd16);
        csr_rd(4'd4, rd);
        chk("B_drop0", 64'(rd), 64'(B_DROPS));
        csr_rd(4'd5, rd);
        chk("B_drop1", 64'(rd), 64'(B_DROPS));

        // C: waitrequest stall on first write holds address/data, single pop
        apply_reset();
        csr_wr(4'd0, 32'h1);
        mem_waitrequest = 1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            d0 = rnd36();
            port0_st_valid = 1; port0_st_data = d0;
            push(1'b0, 20'(k), d0);
        end
        @(posedge clk); #1 port0_st_valid = 0;
        wait_mem_write("C_mem_write_timeout");
        hold_addr = mem_address;
        hold_data = mem_writedata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("C_hold_write", 64'(mem_write), 64'd1);
            chk("C_hold_addr", 64'(mem_address), 64'(hold_addr));
            chk("C_hold_data", mem_writedata, hold_data);
        end
        @(posedge clk); #1 mem_waitrequest = 0;
        wait_empty("C_drain");

        // D: LIMIT=1 with wrap, five port-1 beats
        apply_reset();
        csr_wr(4'd2, 32'd1);
        csr_wr(4'd0, 32'h5);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            d1 = rnd36();
            port1_st_valid = 1; port1_st_data = d1;
            push(1'b1, 20'(k % 2), d1);
        end
        @(posedge clk); #1 port1_st_valid = 0;
        wait_empty("D_drain");
        csr_rd(4'd0, rd);
        chk("D_ctrl_readback", 64'(rd), 64'h4);

        // E: three buffered beats, STOP drains them, later beats ignored
        apply_reset();
        csr_wr(4'd0, 32'h1);
        mem_waitrequest = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            d1 = rnd36();
            port1_st_valid = 1; port1_st_data = d1;
            push(1'b1, 20'(k), d1);
        end
        @(posedge clk); #1 port1_st_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        csr_address = 4'd0; csr_writedata = 32'h2; csr_write = 1; mem_waitrequest = 0;
        @(posedge clk); #1;
        csr_write = 0; csr_address = 4'd1; csr_read = 1;
        @(posedge clk); #1;
        csr_read = 0;
        chk("E_status_drain", 64'(csr_readdata), 64'd2);
        wait_empty("E_drain");
        repeat (3) @(posedge clk);
        csr_rd(4'd1, rd);
        chk("E_status_done", 64'(rd), 64'd3);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            port0_st_valid = 1; port0_st_data = rnd36();
        end
        @(posedge clk); #1 port0_st_valid = 0;
        repeat (6) @(posedge clk);
        csr_rd(4'd3, rd);
        chk("E_wrptr", 64'(rd), 64'd3);

        // F: reset asserted while a write is pending
        apply_reset();
        csr_wr(4'd0, 32'h9);
        chk("F_snoop_set", 64'(snoop_reset), 64'd1);
        mem_waitrequest = 1;
        @(posedge clk); #1;
        port0_st_valid = 1; port0_st_data = rnd36();
        @(posedge clk); #1 port0_st_valid = 0;
        wait_mem_write("F_mem_write_timeout");
        reset = 1;
        #1;
        chk("F_rst_mem_write", 64'(mem_write), 64'd0);
        chk("F_rst_snoop", 64'(snoop_reset), 64'd0);
        chk("F_rst_addr", 64'(mem_address), 64'd0);
        mem_waitrequest = 0;
        @(posedge clk); #1 reset = 0;
        csr_rd(4'd1, rd);
        chk("F_status_idle", 64'(rd), 64'd0);
        repeat (4) @(posedge clk);
        chk("F_mem_write_idle", 64'(mem_write), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/capture_arbiter.md
# capture_arbiter

Sequencer and arbiter that shares one Avalon-MM write master between the two 36-bit port snoop streams, for capture into a single trace memory. Buffers each stream in a small FIFO, round-robins the buffered beats into 64-bit tagged memory words at an incrementing address, and runs a CSR-controlled arm/run/drain/done capture sequence with wrap or one-shot fill. Sits between the per-port snoop taps and the capture memory, and owns the snoop reset.

## Interface
- ADDR_W, 20, memory word-address width
- DEPTH, 4, per-port FIFO entries (power of 2, ≥2)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- port0_st_data  in  36  port 0 beat
- port0_st_valid  in  1  port 0 beat valid (no backpressure)
- port1_st_data  in  36  port 1 beat
- port1_st_valid  in  1  port 1 beat valid (no backpressure)
- mem_address  out  ADDR_W  write word address
- mem_write  out  1  write request
- mem_writedata  out  64  tagged word
- mem_waitrequest  in  1  slave stall
- csr_address  in  4  CSR word address
- csr_write  in  1  CSR write strobe
- csr_read  in  1  CSR read strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data
- snoop_reset  out  1  reset to snoop taps (CTRL bit 3)

## Operation
- Memory word: [63:60]=4'hF, [59]=port id, [58:56]=0, [55:36]=low 20 bits of write pointer, [35:0]=beat.
- CSR map: 0 CTRL (W: bit0 ARM, bit1 STOP, bit2 WRAP, bit3 SNOOP_RST; R: {28'b0, SNOOP_RST, WRAP, 2'b0}), 1 STATUS (R: bits[1:0] state IDLE=0 RUN=1 DRAIN=2 DONE=3), 2 LIMIT (R/W, last address, reset all-ones), 3 WRPTR (R), 4 DROP0 (R), 5 DROP1 (R). Unmapped reads 0; writes to read-only ignored. ARM/STOP are pulses, not stored.
- FSM: IDLE –ARM→ RUN (wrptr, drop counts, FIFOs cleared). RUN –STOP→ DRAIN. RUN or DRAIN: write accepted at wrptr==LIMIT: WRAP=1 → wrptr=0, stay; WRAP=0 → DONE, FIFOs flushed. DRAIN with both FIFOs empty and no pending write → DONE. DONE –ARM→ RUN. ARM in RUN/DRAIN ignored; STOP outside RUN ignored; ARM+STOP in one write from IDLE/DONE → RUN.
- FIFO fill only in RUN. Valid beat with own FIFO full → dropped, DROPn++ (32-bit, saturating). Beats outside RUN ignored, not counted.
- Arbiter: round-robin, pointer to last granted port; a lone non-empty FIFO is granted; both non-empty → the other port from last grant. Reset pointer = port 1 (port 0 wins first tie).
- Write accepted when mem_write=1 and mem_waitrequest=0: FIFO pops, wrptr++.

## Timing
- All outputs registered; reset values: mem_write=0, mem_address=0, mem_writedata=0, csr_readdata=0, snoop_reset=0.
- Beat sampled at edge N into empty FIFO, idle master → mem_write high from cycle N+1.
- Avalon hold: while mem_write=1 and mem_waitrequest=1, address/data/grant stable; no re-arbitration.
- Sustained throughput one word/cycle with mem_waitrequest=0; FIFO push and pop same cycle allowed at full.
- csr_readdata valid cycle after csr_read; held otherwise.
- Reset mid-capture: everything to reset values immediately; pending write abandoned.

## Configuration
- CAPTURE_ARBITER_DROP_CNT_EN defined: DROP0/DROP1 counters implemented as above. Undefined: counters absent, addresses 4/5 read 0, drops silent.

## Test plan
- LIMIT=3, WRAP=0, ARM, 6 port-0 beats on consecutive cycles → 4 writes addr 0..3, [59]=0, data matches, STATUS=3, DROP0=0 beyond FIFO overflow.
- Both ports valid every cycle, waitrequest=0 → writes alternate port0/port1 starting port 0, DROP0/DROP1 increment once each per 2 cycles after FIFOs fill.
- waitrequest high 5 cycles on first write → mem_address/mem_writedata constant throughout, single pop.
- LIMIT=1, WRAP=1, 5 beats → addresses 0,1,0,1,0; [55:36] matches address.
- 3 beats buffered, STOP with waitrequest=0 → state 2, all 3 written, then state 3; later beats ignored.
- Reset asserted mid-write → mem_write=0 same cycle, STATUS=0, snoop_reset=0.
